// File: rtl/exec_pkg.sv
// Shared constants, opcode/state enums and the EX/MEM register layout for the execute stage.
package exec_pkg;
  localparam int LANES    = 9;
  localparam int LANE_W   = 16;
  localparam int SCALAR_W = 24;
  localparam int REG_W    = 4;
  localparam int IMM_W    = 16;
  localparam int VEC_W    = LANES * LANE_W;

  typedef enum logic [1:0] {
    OPT_SCALAR = 2'd0,
    OPT_VECTOR = 2'd1,
    OPT_MEM    = 2'd2,
    OPT_NOP    = 2'd3
  } optype_t;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHL   = 4'd5,
    OP_SHR   = 4'd6,
    OP_MUL   = 4'd7,
    OP_VMULS = 4'd8
  } opcode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0]          op_type;
    logic [3:0]          op_code;
    logic [REG_W-1:0]    rc;
    logic                mem_write;
    logic                mem_to_reg;
    logic                reg_write;
    logic                reg_write_v;
    logic                mode_sel;
    logic [VEC_W-1:0]    address1;
    logic [SCALAR_W-1:0] address2;
    logic [VEC_W-1:0]    write_data;
  } exout_t;

  // Only the two vector multiplies go through the lane-serial multiplier.
  function automatic logic is_multicycle(input logic [1:0] op_type, input logic [3:0] op_code);
    return (op_type == OPT_VECTOR) && ((op_code == OP_MUL) || (op_code == OP_VMULS));
  endfunction
endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU for the single-cycle vector operations.
module vec_lane_alu
  import exec_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [3:0]        shamt,
  output logic [LANE_W-1:0] y
);

  // Lane result; multiply and unknown codes yield zero here.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << shamt;
      OP_SHR:  y = a >> shamt;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle scalar/vector/memory ops plus lane-serial vector multiply,
// feeding the EX/MEM register consumed by memoryStage.
module execute_stage
  import exec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          opType,
  input  logic [3:0]          opCode,
  input  logic [VEC_W-1:0]    srcAV,
  input  logic [VEC_W-1:0]    srcBV,
  input  logic [SCALAR_W-1:0] srcAS,
  input  logic [SCALAR_W-1:0] srcBS,
  input  logic [IMM_W-1:0]    imm,
  input  logic [REG_W-1:0]    Rc_in,
  input  logic                memWrite_in,
  input  logic                memToReg_in,
  input  logic                regWrite_in,
  input  logic                regWriteV_in,
  input  logic                modeSel_in,
  output logic                stall,
  output logic [1:0]          opType_out,
  output logic [3:0]          opCode_out,
  output logic [REG_W-1:0]    Rc,
  output logic                memWrite,
  output logic                memToReg,
  output logic                regWrite,
  output logic                regWriteV,
  output logic                modeSel,
  output logic [VEC_W-1:0]    address1,
  output logic [SCALAR_W-1:0] address2,
  output logic [VEC_W-1:0]    writeData
);

  localparam logic [3:0] LAST_LANE = 4'(LANES - 1);

  state_t              state_r, state_n_s;
  logic [3:0]          cnt_r, cnt_n_s;
  exout_t              res_r, res_n_s, single_s, cap_r;
  logic [VEC_W-1:0]    acc_r, acc_n_s, cap_a_r, cap_b_r, lane_res_s, mem_lanes_s;
  logic [LANE_W-1:0]   cap_s_r, mul_a_s, mul_b_s, prod_s;
  logic                cap_muls_r, capture_s, mc_s;
  logic [SCALAR_W-1:0] scalar_res_s, imm_sx_s;
  int                  lane_base_s;

  assign imm_sx_s = {{(SCALAR_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign mc_s     = is_multicycle(opType, opCode);

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      vec_lane_alu u_alu (
        .op    (opCode),
        .a     (srcAV[g*LANE_W +: LANE_W]),
        .b     (srcBV[g*LANE_W +: LANE_W]),
        .shamt (srcBS[3:0]),
        .y     (lane_res_s[g*LANE_W +: LANE_W])
      );
      assign mem_lanes_s[g*LANE_W +: LANE_W] = srcAV[g*LANE_W +: LANE_W] + imm;
    end
  endgenerate

  // Scalar ALU; shifting by 24 or more naturally clears every bit.
  always_comb begin
    scalar_res_s = srcAS;
    case (opCode)
      OP_ADD:  scalar_res_s = srcAS + srcBS;
      OP_SUB:  scalar_res_s = srcAS - srcBS;
      OP_AND:  scalar_res_s = srcAS & srcBS;
      OP_OR:   scalar_res_s = srcAS | srcBS;
      OP_XOR:  scalar_res_s = srcAS ^ srcBS;
      OP_SHL:  scalar_res_s = srcAS << srcBS[4:0];
      OP_SHR:  scalar_res_s = srcAS >> srcBS[4:0];
      OP_MUL:  scalar_res_s = srcAS * srcBS;
      default: scalar_res_s = srcAS;
    endcase
  end

  // Result of a single-cycle op; also the control snapshot taken when a multiply starts.
  always_comb begin
    single_s             = '0;
    single_s.op_type     = opType;
    single_s.op_code     = opCode;
    single_s.rc          = Rc_in;
    single_s.mode_sel    = modeSel_in;
    single_s.mem_write   = memWrite_in;
    single_s.mem_to_reg  = memToReg_in;
    single_s.reg_write   = regWrite_in;
    single_s.reg_write_v = regWriteV_in;
    single_s.write_data  = srcBV;
    case (opType)
      OPT_SCALAR: single_s.address2 = scalar_res_s;
      OPT_VECTOR: single_s.address1 = lane_res_s;
      OPT_MEM: begin
        single_s.address2 = srcAS + imm_sx_s;
        single_s.address1 = mem_lanes_s;
      end
      default: begin
        single_s.mem_write   = 1'b0;
        single_s.mem_to_reg  = 1'b0;
        single_s.reg_write   = 1'b0;
        single_s.reg_write_v = 1'b0;
        single_s.write_data  = '0;
      end
    endcase
  end

  // Shared 16x16 multiplier fed from the captured lane selected by the counter.
  always_comb begin
    lane_base_s = int'(cnt_r) * LANE_W;
    mul_a_s     = cap_a_r[lane_base_s +: LANE_W];
    if (cap_muls_r) begin
      mul_b_s = cap_s_r;
    end else begin
      mul_b_s = cap_b_r[lane_base_s +: LANE_W];
    end
    prod_s = mul_a_s * mul_b_s;
  end

  // FSM next state, lane accumulation, stall and next EX/MEM contents.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    acc_n_s   = acc_r;
    res_n_s   = res_r;
    capture_s = 1'b0;
    stall     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en && mc_s) begin
          stall     = 1'b1;
          capture_s = 1'b1;
          state_n_s = ST_MUL;
          cnt_n_s   = 4'd0;
          acc_n_s   = '0;
          res_n_s   = '0;
        end else if (en) begin
          res_n_s = single_s;
        end else begin
          res_n_s = res_r;
        end
      end
      ST_MUL: begin
        stall = (cnt_r != LAST_LANE);
        if (en) begin
          acc_n_s[lane_base_s +: LANE_W] = prod_s;
          if (cnt_r == LAST_LANE) begin
            res_n_s          = cap_r;
            res_n_s.address1 = acc_n_s;
            state_n_s        = ST_IDLE;
            cnt_n_s          = 4'd0;
          end else begin
            cnt_n_s = cnt_r + 4'd1;
          end
        end else begin
          cnt_n_s = cnt_r;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        cnt_n_s   = 4'd0;
      end
    endcase
  end

  // State, counter, accumulator, captured operands and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      acc_r      <= '0;
      res_r      <= '0;
      cap_r      <= '0;
      cap_a_r    <= '0;
      cap_b_r    <= '0;
      cap_s_r    <= '0;
      cap_muls_r <= 1'b0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      acc_r   <= acc_n_s;
      res_r   <= res_n_s;
      if (capture_s) begin
        cap_r      <= single_s;
        cap_a_r    <= srcAV;
        cap_b_r    <= srcBV;
        cap_s_r    <= srcBS[LANE_W-1:0];
        cap_muls_r <= (opCode == OP_VMULS);
      end
    end
  end

  assign opType_out = res_r.op_type;
  assign opCode_out = res_r.op_code;
  assign Rc         = res_r.rc;
  assign memWrite   = res_r.mem_write;
  assign memToReg   = res_r.mem_to_reg;
  assign regWrite   = res_r.reg_write;
  assign regWriteV  = res_r.reg_write_v;
  assign modeSel    = res_r.mode_sel;
  assign address1   = res_r.address1;
  assign address2   = res_r.address2;
  assign writeData  = res_r.write_data;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: an upstream driver holds each instruction while stall is
// high, pushes the modelled result when the stage accepts it, and a monitor compares the outputs.
module tb_execute_stage;
  localparam int LANES = 9;
  localparam int VW    = 144;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, en;
  logic [1:0]     opType;
  logic [3:0]     opCode;
  logic [VW-1:0]  srcAV, srcBV;
  logic [23:0]    srcAS, srcBS;
  logic [15:0]    imm;
  logic [3:0]     Rc_in;
  logic           memWrite_in, memToReg_in, regWrite_in, regWriteV_in, modeSel_in;
  logic           stall;
  logic [1:0]     opType_out;
  logic [3:0]     opCode_out, Rc;
  logic           memWrite, memToReg, regWrite, regWriteV, modeSel;
  logic [VW-1:0]  address1, writeData;
  logic [23:0]    address2;

  execute_stage dut (
    .clk(clk), .rst(rst), .en(en), .opType(opType), .opCode(opCode),
    .srcAV(srcAV), .srcBV(srcBV), .srcAS(srcAS), .srcBS(srcBS), .imm(imm), .Rc_in(Rc_in),
    .memWrite_in(memWrite_in), .memToReg_in(memToReg_in), .regWrite_in(regWrite_in),
    .regWriteV_in(regWriteV_in), .modeSel_in(modeSel_in), .stall(stall),
    .opType_out(opType_out), .opCode_out(opCode_out), .Rc(Rc), .memWrite(memWrite),
    .memToReg(memToReg), .regWrite(regWrite), .regWriteV(regWriteV), .modeSel(modeSel),
    .address1(address1), .address2(address2), .writeData(writeData)
  );

  typedef struct packed {
    logic [1:0]    op_type;
    logic [3:0]    op_code;
    logic [3:0]    rc;
    logic          mw, mtr, rw, rwv, ms;
    logic [VW-1:0] a1;
    logic [23:0]   a2;
    logic [VW-1:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   f_rst = 1'b0, f_acc = 1'b0, f_bub = 1'b0;

  // Reference: results computed straight from the instruction rules with integer arithmetic.
  function automatic exp_t model();
    exp_t e;
    longint unsigned a, b, s;
    int unsigned la, lb, r, sh;
    int si;
    e = '0;
    e.op_type = opType; e.op_code = opCode; e.rc = Rc_in; e.ms = modeSel_in;
    if (opType != 2'd3) begin
      e.mw = memWrite_in; e.mtr = memToReg_in; e.rw = regWrite_in; e.rwv = regWriteV_in;
      e.wd = srcBV;
    end
    if (opType == 2'd0) begin
      a = srcAS; b = srcBS;
      case (opCode)
        4'd0: s = a + b;
        4'd1: s = a + 64'd16777216 - b;
        4'd2: s = a & b;
        4'd3: s = a | b;
        4'd4: s = a ^ b;
        4'd5: s = a * (64'd1 << srcBS[4:0]);
        4'd6: s = a / (64'd1 << srcBS[4:0]);
        4'd7: s = a * b;
        default: s = a;
      endcase
      e.a2 = 24'(s % 64'd16777216);
    end else if (opType == 2'd1) begin
      sh = srcBS[3:0];
      for (int i = 0; i < LANES; i++) begin
        la = srcAV[16*i +: 16]; lb = srcBV[16*i +: 16];
        case (opCode)
          4'd0: r = la + lb;
          4'd1: r = la + 32'd65536 - lb;
          4'd2: r = la & lb;
          4'd3: r = la | lb;
          4'd4: r = la ^ lb;
          4'd5: r = la * (32'd1 << sh);
          4'd6: r = la / (32'd1 << sh);
          4'd7: r = la * lb;
          4'd8: r = la * srcBS[15:0];
          default: r = 32'd0;
        endcase
        e.a1[16*i +: 16] = 16'(r % 32'd65536);
      end
    end else if (opType == 2'd2) begin
      si = imm[15] ? int'(imm) - 65536 : int'(imm);
      e.a2 = 24'((longint'(srcAS) + longint'(si) + 64'd16777216) % 64'd16777216);
      for (int i = 0; i < LANES; i++) begin
        la = srcAV[16*i +: 16];
        e.a1[16*i +: 16] = 16'((la + imm) % 32'd65536);
      end
    end
    return e;
  endfunction

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: decide what the last edge should have produced, then compare just after it.
  always @(posedge clk) begin : monitor
    bit r, a, b;
    exp_t got, want;
    r = f_rst; a = f_acc; b = f_bub;
    #2;
    got = {opType_out, opCode_out, Rc, memWrite, memToReg, regWrite, regWriteV, modeSel,
           address1, address2, writeData};
    if (r) begin
      vectors++;
      if (got != '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %h expected 0", got);
      end
    end else if (a) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL result: got %h with no expected entry", got);
      end else begin
        want = exp_q.pop_front();
        if (got != want) begin
          miscompares++;
          $display("FAIL result: got %h expected %h", got, want);
        end
      end
    end else if (b) begin
      vectors++;
      if ({memWrite, memToReg, regWrite, regWriteV} != 4'b0000) begin
        miscompares++;
        $display("FAIL bubble_enables: got %b expected 0000", {memWrite, memToReg, regWrite, regWriteV});
      end
    end
  end

  task automatic rst_step();
    rst = 1'b1;
    @(negedge clk);
    f_rst = 1'b1; f_acc = 1'b0; f_bub = 1'b0;
    @(posedge clk); #1;
  endtask

  // Present the current instruction until accepted (en & !stall), or for max_steps when aborting.
  task automatic run(input bit rnd_en, input int gap_at, input int gap_len, input bit abort,
                     input int max_steps, output int ns, output int nst);
    ns = 0; nst = 0;
    for (int k = 0; k < max_steps; k++) begin
      if (rnd_en) en = ($urandom_range(0, 7) != 0);
      else        en = !((k >= gap_at) && (k < gap_at + gap_len));
      @(negedge clk);
      if (stall) nst++;
      f_rst = rst; f_acc = !rst && en && !stall; f_bub = !rst && en && stall;
      if (f_acc) exp_q.push_back(model());
      @(posedge clk); #1;
      ns++;
      if (f_acc) return;
    end
    if (!abort) check_int("accept_timeout", ns, -1);
  endtask

  task automatic set_instr(input logic [1:0] t, input logic [3:0] c);
    opType = t; opCode = c; Rc_in = 4'($urandom);
    {memWrite_in, memToReg_in, regWrite_in, regWriteV_in, modeSel_in} = 5'b11111;
  endtask

  task automatic rand_instr();
    opType = 2'($urandom_range(0, 3));
    opCode = (opType == 2'd1) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(0, 15));
    for (int i = 0; i < LANES; i++) begin
      srcAV[16*i +: 16] = 16'($urandom);
      srcBV[16*i +: 16] = 16'($urandom);
    end
    srcAS = 24'($urandom);
    srcBS = ($urandom_range(0, 1) != 0) ? 24'($urandom_range(0, 31)) : 24'($urandom);
    imm   = 16'($urandom);
    Rc_in = 4'($urandom);
    {memWrite_in, memToReg_in, regWrite_in, regWriteV_in, modeSel_in} = 5'($urandom);
  endtask

  initial begin
    int ns, nst;
    rst = 1'b1; en = 1'b0;
    srcAV = '0; srcBV = '0; srcAS = '0; srcBS = '0; imm = '0;
    set_instr(2'd3, 4'd0);
    rst_step(); rst_step();
    check_int("reset_stall", int'(stall), 0);
    rst = 1'b0;

    // NOP with all write controls requested
    run(1'b0, 0, 0, 1'b0, 100, ns, nst);
    check_int("nop_latency", ns, 1);

    // vector ADD that wraps every lane to zero
    set_instr(2'd1, 4'd0);
    for (int i = 0; i < LANES; i++) begin
      srcAV[16*i +: 16] = 16'hFFFF; srcBV[16*i +: 16] = 16'd1;
    end
    run(1'b0, 0, 0, 1'b0, 100, ns, nst);
    check_int("vadd_latency", ns, 1);

    // memory: base 500, imm -4, store data 35
    set_instr(2'd2, 4'd0);
    srcAS = 24'd500; imm = 16'hFFFC; srcBV = 144'd35;
    run(1'b0, 0, 0, 1'b0, 100, ns, nst);

    // VMUL lanes A=i+2, B=3
    set_instr(2'd1, 4'd7);
    for (int i = 0; i < LANES; i++) begin
      srcAV[16*i +: 16] = 16'(i + 2); srcBV[16*i +: 16] = 16'd3;
    end
    run(1'b0, 0, 0, 1'b0, 100, ns, nst);
    check_int("vmul_steps", ns, 10);
    check_int("vmul_stall_cycles", nst, 9);

    // same VMUL frozen by en=0 for three cycles mid-operation
    run(1'b0, 4, 3, 1'b0, 100, ns, nst);
    check_int("vmul_freeze_steps", ns, 13);
    check_int("vmul_freeze_stall", nst, 12);

    // VMULS aborted by reset while lane 4 is in the multiplier
    set_instr(2'd1, 4'd8);
    srcBS = 24'h00ABCD;
    run(1'b0, 0, 0, 1'b1, 5, ns, nst);
    rst_step();
    rst = 1'b0;
    set_instr(2'd0, 4'd0);
    srcAS = 24'd1234; srcBS = 24'd4321;
    run(1'b0, 0, 0, 1'b0, 100, ns, nst);
    check_int("post_abort_stall", nst, 0);
    check_int("post_abort_latency", ns, 1);

    for (int n = 0; n < 150; n++) begin
      rand_instr();
      run(1'b1, 0, 0, 1'b0, 200, ns, nst);
    end

    f_rst = 1'b0; f_acc = 1'b0; f_bub = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
